mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 1024, BUSY-state cycle limit before forced completion (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 u_lock  in  2  per-port hold-grant request; index 0 = port 0, index 1 = port 1.
REQ-005 u_rqst  in  2x8  per-port request tag; 0 = no request.
REQ-006 u_trsc  in  2x8  per-port transaction type.
REQ-007 u_addr  in  2x64  per-port address.
REQ-008 u_resp  out  2x8  per-port completion tag.
REQ-009 u_mesi  out  2x8  per-port returned MESI state.
REQ-010 d_lock  out  1  downstream lock.
REQ-011 d_rqst  out  8  downstream request tag.
REQ-012 d_trsc  out  8  downstream transaction type.
REQ-013 d_addr  out  64  downstream address.
REQ-014 d_resp  in  8  downstream completion tag.
REQ-015 d_mesi  in  8  downstream MESI state.
REQ-016 timeout  out  1  one-cycle pulse on forced completion.

Function
REQ-017 Port i pending SHALL mean u_rqst[i] != 0 and u_rqst[i] != u_resp[i].
REQ-018 FSM states: IDLE, BUSY, HOLD.
REQ-019 IDLE: if any port is pending, grant it; if both are pending, grant round-robin, preferring the port not granted last.
REQ-020 On grant: latch tag, trsc and addr into registers; enter BUSY. d_rqst/d_trsc/d_addr SHALL carry the latched values from the next cycle (1-cycle issue latency).
REQ-021 d_rqst SHALL be 0 in IDLE and HOLD; d_trsc and d_addr SHALL be 0 in IDLE.
REQ-022 BUSY: completion when d_resp == latched tag. Next cycle: u_resp[g] <= tag, u_mesi[g] <= d_mesi, d_rqst <= 0.
REQ-023 On completion: if u_lock[g]=1, enter HOLD; otherwise enter IDLE.
REQ-024 HOLD: only port g may be granted (BUSY again once pending); drop to IDLE when u_lock[g]=0; the other port waits.
REQ-025 d_lock SHALL equal u_lock[g] in BUSY and HOLD, and 0 in IDLE.
REQ-026 Changes to upstream inputs of the granted port while in BUSY SHALL be ignored (latched values are used).
REQ-027 Non-granted port outputs u_resp/u_mesi SHALL hold their last values.
REQ-028 Back-to-back: completion observed at cycle r → new grant evaluated at r+1 → d_rqst at r+2.
REQ-029 A completion and a new pending request in the same cycle SHALL be handled serially: completion first, new request at the next IDLE/HOLD evaluation.

Reset
REQ-030 rst SHALL force: state IDLE; last-grant = port 1 (so port 0 wins the first tie); d_* = 0; u_resp = 0; u_mesi = 0; timeout = 0; counter = 0.
REQ-031 rst mid-transaction SHALL abandon it; no completion is reported.

Configuration
REQ-032 Macro MEM_ARB_TIMEOUT_EN compiles in a BUSY-cycle counter that is cleared on entry to BUSY.
REQ-033 With MEM_ARB_TIMEOUT_EN: when the counter reaches TIMEOUT without completion, the block SHALL complete with u_resp[g] = tag, u_mesi[g] = 0, pulse timeout, and go to IDLE regardless of lock.
REQ-034 Without MEM_ARB_TIMEOUT_EN: no counter; timeout tied to 0; BUSY waits indefinitely.

Structure
REQ-035 Package mem_pkg SHALL hold the width constants (TAG_W=8, TRSC_W=8, ADDR_W=64, MESI_W=8), the MESI encodings, and the FSM state enum.
REQ-036 Sub-module rr_arb2 SHALL implement 2-way round-robin selection: inputs req[1:0] and last; output gnt index.

Verification
REQ-037 Port 0: rqst=0x05, addr=0x1000; downstream echoes the tag after 1 cycle with mesi=1 -> d_rqst=0x05 one cycle after the request, u_resp[0]=0x05 and u_mesi[0]=1 one cycle after the echo.
REQ-038 Both ports pending from reset (tags 0x01, 0x02) -> port 0 served first, then port 1; then both pending again -> port 0 served first again (alternation).
REQ-039 Port 1 with u_lock=1 issues tags 0x10 then 0x11 while port 0 is pending -> both port-1 transactions complete before port 0 is granted; d_lock=1 throughout.
REQ-040 Port 0 u_addr changed during BUSY -> d_addr stays at the latched 0x1000.
REQ-041 rst asserted while in BUSY -> next cycle all outputs 0 and state IDLE; the original request is re-arbitrated after reset.
REQ-042 With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, downstream never responds -> after 8 BUSY cycles: timeout pulse, u_resp[0]=tag, u_mesi[0]=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, MESI encodings and FSM state type for the two-port memory arbiter.
package mem_pkg;

    localparam int TAG_W  = 8;
    localparam int TRSC_W = 8;
    localparam int ADDR_W = 64;
    localparam int MESI_W = 8;

    localparam logic [MESI_W-1:0] MESI_I = 8'd0;
    localparam logic [MESI_W-1:0] MESI_S = 8'd1;
    localparam logic [MESI_W-1:0] MESI_E = 8'd2;
    localparam logic [MESI_W-1:0] MESI_M = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        gnt = 1'b0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port upstream to single downstream memory arbiter with lock/hold support.
// Define MEM_ARB_TIMEOUT_EN to add a BUSY-cycle watchdog that forces completion.
module mem_arb
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             u_lock,
    input  logic [1:0][TAG_W-1:0]  u_rqst,
    input  logic [1:0][TRSC_W-1:0] u_trsc,
    input  logic [1:0][ADDR_W-1:0] u_addr,
    output logic [1:0][TAG_W-1:0]  u_resp,
    output logic [1:0][MESI_W-1:0] u_mesi,
    output logic                   d_lock,
    output logic [TAG_W-1:0]       d_rqst,
    output logic [TRSC_W-1:0]      d_trsc,
    output logic [ADDR_W-1:0]      d_addr,
    input  logic [TAG_W-1:0]       d_resp,
    input  logic [MESI_W-1:0]      d_mesi,
    output logic                   timeout
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arb: TIMEOUT must be at least 1");
    end

    state_t              state;
    state_t              next_state;
    logic                gnt_q;
    logic                last_q;
    logic                sel;
    logic [TAG_W-1:0]    tag_q;
    logic [TRSC_W-1:0]   trsc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          pending;
    logic                hit;
    logic                expire;
    logic                forced;
    logic                done;
    logic                grant;
    logic                grant_port;

    // A port whose tag has already been answered is not pending until it presents a new tag.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pending[i] = (u_rqst[i] != '0) && (u_rqst[i] != u_resp[i]);
        end
    end

    rr_arb2 u_rr (
        .req  (pending),
        .last (last_q),
        .gnt  (sel)
    );

    assign hit    = (d_resp == tag_q);
    assign done   = (state == ST_BUSY) && (hit || expire);
    assign forced = expire && !hit;

    // In HOLD only the locked owner may be re-granted.
    assign grant      = ((state == ST_IDLE) && (|pending)) ||
                        ((state == ST_HOLD) && u_lock[gnt_q] && pending[gnt_q]);
    assign grant_port = (state == ST_IDLE) ? sel : gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    next_state = (u_lock[gnt_q] && !forced) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!u_lock[gnt_q]) begin
                    next_state = ST_IDLE;
                end else if (pending[gnt_q]) begin
                    next_state = ST_BUSY;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        d_lock = 1'b0;
        d_rqst = '0;
        d_trsc = '0;
        d_addr = '0;
        case (state)
            ST_BUSY: begin
                d_lock = u_lock[gnt_q];
                d_rqst = tag_q;
                d_trsc = trsc_q;
                d_addr = addr_q;
            end
            ST_HOLD: begin
                d_lock = u_lock[gnt_q];
                d_trsc = trsc_q;
                d_addr = addr_q;
            end
            default: ;
        endcase
    end

    // Grant and completion happen in different states, so they never collide here.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= 1'b0;
            last_q <= 1'b1;
            tag_q  <= '0;
            trsc_q <= '0;
            addr_q <= '0;
            u_resp <= '0;
            u_mesi <= '0;
        end else begin
            if (grant) begin
                gnt_q  <= grant_port;
                last_q <= grant_port;
                tag_q  <= u_rqst[grant_port];
                trsc_q <= u_trsc[grant_port];
                addr_q <= u_addr[grant_port];
            end
            if (done) begin
                u_resp[gnt_q] <= tag_q;
                u_mesi[gnt_q] <= forced ? MESI_I : d_mesi;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    assign expire = (state == ST_BUSY) && (cnt == CNT_W'(TIMEOUT - 1));

    // Counter sits at zero outside BUSY, so every BUSY entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= done && forced;
            if (state != ST_BUSY || done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb; covers the watchdog path when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arb;
    import mem_pkg::*;

    logic                   clk;
    logic                   rst;
    logic [1:0]             u_lock;
    logic [1:0][TAG_W-1:0]  u_rqst;
    logic [1:0][TRSC_W-1:0] u_trsc;
    logic [1:0][ADDR_W-1:0] u_addr;
    logic [1:0][TAG_W-1:0]  u_resp;
    logic [1:0][MESI_W-1:0] u_mesi;
    logic                   d_lock;
    logic [TAG_W-1:0]       d_rqst;
    logic [TRSC_W-1:0]      d_trsc;
    logic [ADDR_W-1:0]      d_addr;
    logic [TAG_W-1:0]       d_resp;
    logic [MESI_W-1:0]      d_mesi;
    logic                   timeout;

    int checks = 0;
    int fails  = 0;

    mem_arb #(.TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .u_lock  (u_lock),
        .u_rqst  (u_rqst),
        .u_trsc  (u_trsc),
        .u_addr  (u_addr),
        .u_resp  (u_resp),
        .u_mesi  (u_mesi),
        .d_lock  (d_lock),
        .d_rqst  (d_rqst),
        .d_trsc  (d_trsc),
        .d_addr  (d_addr),
        .d_resp  (d_resp),
        .d_mesi  (d_mesi),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [7:0] tag, input logic [7:0] trsc,
                                 input logic [63:0] addr, input logic lock);
        u_rqst[port] = tag;
        u_trsc[port] = trsc;
        u_addr[port] = addr;
        u_lock[port] = lock;
    endtask

    task automatic respond(input logic [7:0] tag, input logic [7:0] mesi);
        d_resp = tag;
        d_mesi = mesi;
    endtask

    task automatic stepClock(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        u_lock = '0;
        u_rqst = '0;
        u_trsc = '0;
        u_addr = '0;
        d_resp = '0;
        d_mesi = '0;
        stepClock(2);

        checkOutput("rst_d_rqst",  d_rqst, 0);
        checkOutput("rst_d_trsc",  d_trsc, 0);
        checkOutput("rst_d_addr",  d_addr, 0);
        checkOutput("rst_d_lock",  d_lock, 0);
        checkOutput("rst_u_resp",  u_resp, 0);
        checkOutput("rst_u_mesi",  u_mesi, 0);
        checkOutput("rst_timeout", timeout, 0);

        // single port-0 transaction; address change while BUSY must be ignored
        rst = 1'b0;
        applyStimulus(0, 8'h05, 8'h02, 64'h1000, 1'b0);
        stepClock(1);
        checkOutput("p0_d_rqst", d_rqst, 8'h05);
        checkOutput("p0_d_trsc", d_trsc, 8'h02);
        checkOutput("p0_d_addr", d_addr, 64'h1000);
        checkOutput("p0_d_lock", d_lock, 0);
        u_addr[0] = 64'h2000;
        stepClock(1);
        checkOutput("p0_addr_latched", d_addr, 64'h1000);
        checkOutput("p0_no_resp_yet", u_resp[0], 0);
        respond(8'h05, MESI_S);
        stepClock(1);
        checkOutput("p0_u_resp", u_resp[0], 8'h05);
        checkOutput("p0_u_mesi", u_mesi[0], 8'h01);
        checkOutput("p0_idle_rqst", d_rqst, 0);
        checkOutput("p0_idle_addr", d_addr, 0);
        respond(8'h00, 8'h00);

        // both ports pending out of reset: port 0 first, then alternation
        rst = 1'b1;
        applyStimulus(0, 8'h01, 8'h00, 64'h0100, 1'b0);
        applyStimulus(1, 8'h02, 8'h00, 64'h0200, 1'b0);
        stepClock(2);
        checkOutput("rr_rst_resp", u_resp, 0);
        rst = 1'b0;
        stepClock(1);
        checkOutput("rr_first_p0", d_rqst, 8'h01);
        respond(8'h01, MESI_E);
        stepClock(1);
        checkOutput("rr_p0_resp", u_resp[0], 8'h01);
        checkOutput("rr_p0_mesi", u_mesi[0], 8'h02);
        checkOutput("rr_gap_rqst", d_rqst, 0);
        respond(8'h00, 8'h00);
        stepClock(1);
        checkOutput("rr_then_p1", d_rqst, 8'h02);
        checkOutput("rr_p1_addr", d_addr, 64'h0200);
        respond(8'h02, MESI_M);
        stepClock(1);
        checkOutput("rr_p1_resp", u_resp[1], 8'h02);
        checkOutput("rr_p1_mesi", u_mesi[1], 8'h03);
        checkOutput("rr_p0_held", u_resp[0], 8'h01);
        respond(8'h00, 8'h00);
        applyStimulus(0, 8'h03, 8'h00, 64'h0300, 1'b0);
        applyStimulus(1, 8'h04, 8'h00, 64'h0400, 1'b0);
        stepClock(1);
        checkOutput("rr_again_p0", d_rqst, 8'h03);
        respond(8'h03, MESI_S);
        applyStimulus(0, 8'h07, 8'h00, 64'h0700, 1'b0);
        stepClock(1);
        checkOutput("rr_p0_resp3", u_resp[0], 8'h03);
        checkOutput("rr_serial_idle", d_rqst, 0);
        respond(8'h00, 8'h00);
        stepClock(1);
        checkOutput("rr_tie_p1", d_rqst, 8'h04);
        respond(8'h04, MESI_S);
        stepClock(1);
        checkOutput("rr_p1_resp4", u_resp[1], 8'h04);
        respond(8'h00, 8'h00);
        stepClock(1);
        checkOutput("rr_p0_tag7", d_rqst, 8'h07);
        respond(8'h07, MESI_S);
        stepClock(1);
        checkOutput("rr_p0_resp7", u_resp[0], 8'h07);
        respond(8'h00, 8'h00);

        // port 1 holds the grant across two transactions while port 0 waits
        applyStimulus(1, 8'h10, 8'h01, 64'h1010, 1'b1);
        stepClock(1);
        checkOutput("lk_d_rqst10", d_rqst, 8'h10);
        checkOutput("lk_d_lock_a", d_lock, 1);
        applyStimulus(0, 8'h20, 8'h01, 64'h2020, 1'b0);
        respond(8'h10, MESI_S);
        stepClock(1);
        checkOutput("lk_hold_rqst", d_rqst, 0);
        checkOutput("lk_d_lock_b", d_lock, 1);
        checkOutput("lk_p1_resp10", u_resp[1], 8'h10);
        respond(8'h00, 8'h00);
        applyStimulus(1, 8'h11, 8'h01, 64'h1111, 1'b1);
        stepClock(1);
        checkOutput("lk_d_rqst11", d_rqst, 8'h11);
        checkOutput("lk_d_lock_c", d_lock, 1);
        respond(8'h11, MESI_E);
        stepClock(1);
        checkOutput("lk_p1_resp11", u_resp[1], 8'h11);
        checkOutput("lk_p0_waits", u_resp[0], 8'h07);
        checkOutput("lk_d_lock_d", d_lock, 1);
        respond(8'h00, 8'h00);
        u_lock[1] = 1'b0;
        stepClock(1);
        checkOutput("lk_release_lock", d_lock, 0);
        checkOutput("lk_release_rqst", d_rqst, 0);
        stepClock(1);
        checkOutput("lk_p0_grant", d_rqst, 8'h20);
        respond(8'h20, MESI_S);
        stepClock(1);
        checkOutput("lk_p0_resp", u_resp[0], 8'h20);
        respond(8'h00, 8'h00);
        applyStimulus(1, 8'h00, 8'h00, 64'h0, 1'b0);

        // reset in BUSY abandons the transaction, even with a matching response present
        applyStimulus(0, 8'h30, 8'h04, 64'h3000, 1'b0);
        stepClock(1);
        checkOutput("mr_busy_rqst", d_rqst, 8'h30);
        rst = 1'b1;
        respond(8'h30, MESI_S);
        stepClock(1);
        checkOutput("mr_d_rqst", d_rqst, 0);
        checkOutput("mr_d_addr", d_addr, 0);
        checkOutput("mr_d_lock", d_lock, 0);
        checkOutput("mr_u_resp", u_resp, 0);
        checkOutput("mr_u_mesi", u_mesi, 0);
        rst = 1'b0;
        respond(8'h00, 8'h00);
        stepClock(1);
        checkOutput("mr_regrant", d_rqst, 8'h30);
        checkOutput("mr_regrant_addr", d_addr, 64'h3000);
        respond(8'h30, MESI_S);
        stepClock(1);
        checkOutput("mr_resp", u_resp[0], 8'h30);
        respond(8'h00, 8'h00);

        // downstream never answers
        applyStimulus(0, 8'h40, 8'h05, 64'h4000, 1'b1);
        d_mesi = 8'h03;
        stepClock(1);
        checkOutput("to_d_rqst", d_rqst, 8'h40);
        checkOutput("to_d_lock", d_lock, 1);
`ifdef MEM_ARB_TIMEOUT_EN
        stepClock(7);
        checkOutput("to_still_busy", d_rqst, 8'h40);
        checkOutput("to_no_pulse_yet", timeout, 0);
        stepClock(1);
        checkOutput("to_pulse", timeout, 1);
        checkOutput("to_u_resp", u_resp[0], 8'h40);
        checkOutput("to_u_mesi", u_mesi[0], 8'h00);
        checkOutput("to_idle_rqst", d_rqst, 0);
        checkOutput("to_idle_lock", d_lock, 0);
        stepClock(1);
        checkOutput("to_pulse_end", timeout, 0);
`else
        stepClock(12);
        checkOutput("nt_still_busy", d_rqst, 8'h40);
        checkOutput("nt_no_timeout", timeout, 0);
        respond(8'h40, MESI_M);
        stepClock(1);
        checkOutput("nt_u_resp", u_resp[0], 8'h40);
        checkOutput("nt_u_mesi", u_mesi[0], 8'h03);
        checkOutput("nt_hold_lock", d_lock, 1);
        respond(8'h00, 8'h00);
        u_lock[0] = 1'b0;
        stepClock(1);
        checkOutput("nt_unlock", d_lock, 0);
`endif

        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end

endmodule
